// File: rtl/axi4_ram_rsp_pkg.sv
// Shared types and constants for the AXI4 block-RAM responder.
// Response codes, write/read FSM state enums and a clog2 helper.
package axi4_ram_rsp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_ADDR,
    R_FETCH,
    R_DATA
  } r_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/axi4_ram_rsp_mem.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
// A same-cycle read of the word being written returns the old contents.
module axi4_ram_rsp_mem #(
  parameter int DW    = 512,
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++)
        if (wstrb[b])
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 INCR-burst slave backed by block RAM; one write and one read in flight.
// Define RAM_RSP_BOUNDS_CHECK_EN to flag out-of-range beats with SLVERR.
module axi4_ram_responder
  import axi4_ram_rsp_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 34,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int DEPTH_WORDS    = 1024
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);

  localparam int LSB = clog2(AXI_DATA_WIDTH/8);
  localparam int IW  = clog2(DEPTH_WORDS);
  localparam int WW  = AXI_ADDR_WIDTH - LSB;
`ifdef RAM_RSP_BOUNDS_CHECK_EN
  localparam int CW  = WW;
`else
  localparam int CW  = IW;
`endif

  w_state_t            w_state;
  logic [CW-1:0]       w_word;
  logic [7:0]          w_len;
  logic [7:0]          w_beat;
  logic                w_err;
  logic                w_oob;
  logic                w_fire;
  logic                w_last;
  logic                w_err_n;

  r_state_t            r_state;
  logic [CW-1:0]       r_word;
  logic [7:0]          r_len;
  logic [7:0]          r_beat;
  logic                r_oob;
  logic                r_oob_q;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;

  logic                unused_addr;

  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

`ifdef RAM_RSP_BOUNDS_CHECK_EN
  assign w_oob = w_word >= CW'(DEPTH_WORDS);
  assign r_oob = r_word >= CW'(DEPTH_WORDS);
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  assign w_fire  = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;
  assign w_last  = w_beat == w_len;
  assign w_err_n = w_err | (S_AXI_WLAST != w_last) | w_oob;

  axi4_ram_rsp_mem #(
    .DW    (AXI_DATA_WIDTH),
    .DEPTH (DEPTH_WORDS),
    .IW    (IW)
  ) u_mem (
    .clk   (S_AXI_ACLK),
    .we    (w_fire && !w_oob),
    .waddr (w_word[IW-1:0]),
    .wdata (S_AXI_WDATA),
    .wstrb (S_AXI_WSTRB),
    .re    (r_state == R_FETCH),
    .raddr (r_word[IW-1:0]),
    .rdata (mem_rdata)
  );

  // Beat count, not WLAST, decides where the burst ends.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state       <= W_ADDR;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_BID     <= '0;
      w_word        <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_ADDR: begin
          if (S_AXI_AWREADY && S_AXI_AWVALID) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_BID     <= S_AXI_AWID;
            w_word        <= S_AXI_AWADDR[LSB +: CW];
            w_len         <= S_AXI_AWLEN;
            w_beat        <= '0;
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end else begin
            S_AXI_AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_last) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= w_err_n ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_word <= w_word + CW'(1);
              w_err  <= w_err_n;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_ADDR;
          end
        end
        default: w_state <= W_ADDR;
      endcase
    end
  end

  assign S_AXI_RDATA = r_oob_q ? '0 : mem_rdata;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state       <= R_ADDR;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RID     <= '0;
      r_word        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_oob_q       <= 1'b0;
    end else begin
      unique case (r_state)
        R_ADDR: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RID     <= S_AXI_ARID;
            r_word        <= S_AXI_ARADDR[LSB +: CW];
            r_len         <= S_AXI_ARLEN;
            r_beat        <= '0;
            r_state       <= R_FETCH;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_FETCH: begin
          S_AXI_RVALID <= 1'b1;
          S_AXI_RLAST  <= r_beat == r_len;
          S_AXI_RRESP  <= r_oob ? RESP_SLVERR : RESP_OKAY;
          r_oob_q      <= r_oob;
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RLAST  <= 1'b0;
            if (S_AXI_RLAST) begin
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_ADDR;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_word  <= r_word + CW'(1);
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed bench for axi4_ram_responder with a read scoreboard and RAM model.
// Follows RAM_RSP_BOUNDS_CHECK_EN when predicting out-of-range results.
module tb_axi4_ram_responder;

  localparam int DW    = 512;
  localparam int AW    = 34;
  localparam int IDW   = 4;
  localparam int DEPTH = 1024;
  localparam int NB    = DW/8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IDW-1:0] awid = '0;
  logic [AW-1:0]  awaddr = '0;
  logic [7:0]     awlen = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [NB-1:0]  wstrb = '0;
  logic           wlast = 1'b0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [IDW-1:0] arid = '0;
  logic [AW-1:0]  araddr = '0;
  logic [7:0]     arlen = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready = 1'b0;

  axi4_ram_responder dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWID    (awid),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWLEN   (awlen),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BID     (bid),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARID    (arid),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
    logic [IDW-1:0] id;
  } rexp_t;

  int checks = 0;
  int errors = 0;
  rexp_t rq[$];
  logic [DW-1:0] model [DEPTH];

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit oob_word(input longint w);
`ifdef RAM_RSP_BOUNDS_CHECK_EN
    return w >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input longint w);
    return int'(w % DEPTH);
  endfunction

  task automatic wr(input logic [AW-1:0] addr, input int len,
                    input logic [IDW-1:0] id, input logic [DW-1:0] base,
                    input bit inc, input logic [NB-1:0] strb,
                    input int bdelay, input bit bad_last);
    longint w0;
    logic [1:0] er;
    int n;
    w0 = longint'(addr >> 6);
    er = 2'b00;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_wait", n < 50, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata  = inc ? DW'(b) : base;
      wstrb  = strb;
      wlast  = (b == len) && !bad_last;
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_wait", 0, 1);
      if (oob_word(w0 + b)) er = 2'b10;
      else
        for (int k = 0; k < NB; k++)
          if (strb[k]) model[widx(w0 + b)][8*k +: 8] = wdata[8*k +: 8];
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    if (bad_last) er = 2'b10;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, er);
    for (int i = 0; i < bdelay; i++) begin
      chk("b_hold", bvalid, 1);
      chk("aw_blocked", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_drop", bvalid, 0);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input int len,
                    input logic [IDW-1:0] id, input bit rnd);
    longint w0;
    rexp_t e;
    int n;
    int got;
    bit hold;
    logic [DW-1:0] prev;
    w0 = longint'(addr >> 6);
    for (int b = 0; b <= len; b++) begin
      e.id   = id;
      e.last = (b == len);
      if (oob_word(w0 + b)) begin
        e.data = '0; e.resp = 2'b10;
      end else begin
        e.data = model[widx(w0 + b)]; e.resp = 2'b00;
      end
      rq.push_back(e);
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_wait", n < 50, 1);
    @(negedge clk);
    arvalid = 1'b0;
    got = 0; n = 0; hold = 1'b0; prev = '0;
    while (got <= len && n < 3000) begin
      if (hold) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, prev);
      end
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && rready) begin
        e = rq.pop_front();
        chk("r_data", rdata, e.data);
        chk("r_resp", rresp, e.resp);
        chk("r_last", rlast, e.last);
        chk("r_id", rid, e.id);
        got++;
        hold = 1'b0;
      end else begin
        hold = rvalid;
        prev = rdata;
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    if (got <= len) begin
      chk("r_beats", got, len + 1);
      rq.delete();
    end
  endtask

  logic [DW-1:0] pat_a;
  logic [DW-1:0] pat_b;
  logic [DW-1:0] pat_c;
  logic [NB-1:0] all1;

  initial begin
    int n;
    pat_a = {16{32'hC0DE_A55A}};
    pat_b = {16{32'h1234_5678}};
    pat_c = {8{64'h0BAD_F00D_DEAD_BEEF}};
    all1  = '1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rlast", rlast, 0);
    rst = 1'b0;

    wr(34'h40, 0, 4'h5, pat_a, 1'b0, all1, 0, 1'b0);
    rd(34'h40, 0, 4'h5, 1'b0);

    wr(34'h0, 255, 4'h2, '0, 1'b1, all1, 0, 1'b0);
    rd(34'h0, 255, 4'h3, 1'b0);

    wr(34'h40, 0, 4'h6, pat_a, 1'b0, all1, 0, 1'b0);
    wr(34'h40, 0, 4'h7, pat_b, 1'b0, NB'(64'hF), 10, 1'b0);
    rd(34'h40, 0, 4'h8, 1'b0);

    rd(34'h0, 15, 4'h9, 1'b1);

    rd(AW'(DEPTH * 64), 0, 4'h1, 1'b0);

    wr(AW'(1022 * 64), 3, 4'hA, '0, 1'b1, all1, 0, 1'b0);
    rd(AW'(1022 * 64), 3, 4'hB, 1'b0);

    wr(34'h80, 1, 4'hC, pat_c, 1'b0, all1, 0, 1'b1);
    rd(34'h80, 1, 4'hD, 1'b0);

    @(negedge clk);
    arid = 4'hE; araddr = 34'h0; arlen = 8'd15; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("pre_rst_rvalid", rvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rlast", rlast, 0);
    chk("mid_rst_arready", arready, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", rvalid, 0);
    end

    rd(34'h40, 0, 4'h4, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
